if_fetch_unit: RTL and testbench

Instruction fetch stage of the core: owns the program counter, issues word fetches to instruction memory over a valid/ready request channel and buffers returned instructions in a small in-order queue. The queue head drives the decode stage, including the immediate generator, as an `inst`/`inst_pc` pair with a valid/ready handshake. Branch/jump resolution redirects the PC through `redirect_valid`; the redirect flushes queued and in-flight instructions.

---
 rtl/if_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction fetch stage. Owns the program counter, issues word fetches to
// instruction memory and buffers returned words in a small in-order queue
// whose head feeds decode as an {inst, inst_pc} pair.
//
// Handshakes: every channel uses strict valid/ready semantics. A transfer
// happens on a rising edge where valid && ready are both high. A producer may
// not change its payload while valid is high and ready is low. The one
// exception is a redirect, which may withdraw a pending fetch request. The
// response channel (imem_rsp_*) has no ready: it cannot be back-pressured.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req_valid/ready  fetch request handshake
//   imem_req_addr         word-aligned fetch address (the current pc)
//   imem_rsp_valid/data   in-order fetch responses, >=1 cycle after accept
//   redirect_valid/pc     branch/jump redirect; flushes queued and in-flight
//   inst_valid/ready      decode handshake on the queue head
//   inst, inst_pc         head instruction word and its pc (0 when empty)
//   misalign_err          only with IF_MISALIGN_TRAP_EN: a misaligned
//                         redirect target was seen; fetch is halted until
//                         an aligned redirect or reset
//
// Parameters:
//   RESET_PC  first pc fetched after reset
//   QDEPTH    queue depth, power of two >= 2; also caps outstanding requests
//
// Build option: define IF_MISALIGN_TRAP_EN to add the misalignment trap.
// Without it, redirect_pc[1:0] is silently cleared.
// ----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int unsigned PW = $clog2(QDEPTH);  // queue / fifo pointer width
  localparam int unsigned CW = PW + 1;          // counters hold 0..QDEPTH
  localparam logic [CW:0] QD_EXT = (CW+1)'(QDEPTH);

  logic          started;
  logic [31:0]   pc;
  logic [CW-1:0] outst;   // accepted requests whose response is not yet seen
  logic [CW-1:0] drop;    // responses still to arrive that belong to a flushed path
  logic [CW-1:0] count;   // valid queue entries

  // Instruction queue
  logic [31:0]   q_word [QDEPTH];
  logic [31:0]   q_pc   [QDEPTH];
  logic [PW-1:0] q_rd, q_wr;

  // In-flight pc fifo: written on request accept, read on every response
  // (kept or dropped), so it stays aligned with the in-order response stream
  // across redirects and is never flushed.
  logic [31:0]   f_pc   [QDEPTH];
  logic [PW-1:0] f_rd, f_wr;

  logic [CW:0]   occ;
  logic          req_fire, push, pop, trap;
  logic [31:0]   target_pc;

`ifdef IF_MISALIGN_TRAP_EN
  logic target_bad;
  assign target_bad = (redirect_pc[1:0] != 2'b00);
  assign target_pc  = redirect_pc;
  assign trap       = misalign_err;
`else
  assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
  assign trap       = 1'b0;
`endif

  // Queue slots already promised: queued words plus live (non-stale)
  // outstanding requests. drop <= outst always holds.
  assign occ            = {1'b0, count} + {1'b0, outst} - {1'b0, drop};
  assign imem_req_valid = started && !redirect_valid && !trap && (occ < QD_EXT);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push           = imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign inst_valid     = (count != '0);
  assign pop            = inst_valid && inst_ready && !redirect_valid;
  assign inst           = inst_valid ? q_word[q_rd] : 32'h0;
  assign inst_pc        = inst_valid ? q_pc[q_rd]   : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
      pc      <= RESET_PC;
      outst   <= '0;
      drop    <= '0;
      count   <= '0;
      q_rd    <= '0;
      q_wr    <= '0;
      f_rd    <= '0;
      f_wr    <= '0;
    end else begin
      started <= 1'b1;
      outst   <= outst + CW'(req_fire) - CW'(imem_rsp_valid);
      if (req_fire)       f_wr <= f_wr + PW'(1);
      if (imem_rsp_valid) f_rd <= f_rd + PW'(1);
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        pc    <= target_pc;
        drop  <= outst - CW'(imem_rsp_valid);
        count <= '0;
        q_rd  <= '0;
        q_wr  <= '0;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (push) q_wr <= q_wr + PW'(1);
        if (pop)  q_rd <= q_rd + PW'(1);
      end
    end
  end

  // Payload storage needs no reset: outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (req_fire) f_pc[f_wr] <= pc;
    if (push) begin
      q_word[q_wr] <= imem_rsp_data;
      q_pc[q_wr]   <= f_pc[f_rd];
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              misalign_err <= 1'b0;
    else if (redirect_valid) misalign_err <= target_bad;
  end
`endif

  // The request throttle makes these impossible; they guard the invariant.
  q_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == CW'(QDEPTH))));
  outst_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(req_fire && !imem_rsp_valid && (outst == CW'(QDEPTH))));

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Directed bench for if_fetch_unit (RESET_PC = 0x100, QDEPTH = 2). A memory
// model answers accepted requests after mem_lat cycles with mem_word(addr)
// and logs every accepted address and every instruction handed to decode.
// Each test task drives its scenario and compares against hand-derived
// expectations.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
`ifdef IF_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  if_fetch_unit #(.RESET_PC(RST_PC), .QDEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
`ifdef IF_MISALIGN_TRAP_EN
    ,
    .misalign_err   (misalign_err)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model and logs ----------------
  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] req_log[$];
  logic [31:0] obs_pc[$];
  logic [31:0] obs_inst[$];
  int          acc_total = 0;
  int          pop_total = 0;
  int          mem_lat   = 1;
  bit          rand_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic clear_logs();
    req_log.delete();
    obs_pc.delete();
    obs_inst.delete();
  endtask

  // Drives response/ready at each falling edge, then 2 time units later
  // records what the coming rising edge will accept or pop.
  initial begin : mem_model
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (!rst_n) begin
        pend_q.delete();
      end else if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end
      imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #2;
      if (rst_n && imem_req_valid && imem_req_ready) begin
        pend_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
        req_log.push_back(imem_req_addr);
        acc_total++;
      end
      if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
        obs_pc.push_back(inst_pc);
        obs_inst.push_back(inst);
        pop_total++;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    acc_total = 0; pop_total = 0;
    clear_logs();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got %h exp 0", inst_pc); end
    checks++; if (imem_req_addr !== RST_PC) begin errors++; $display("FAIL reset_pc got %h exp %h", imem_req_addr, RST_PC); end
`ifdef IF_MISALIGN_TRAP_EN
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign_err); end
`endif
    repeat (2) @(negedge clk);
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_req_valid got %b exp 0", imem_req_valid); end
    acc_total = 0; pop_total = 0;
    clear_logs();
  endtask

  task automatic test_fetch();
    mem_lat = 1; rand_ready = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL fetch_prestart_req got %b exp 0", imem_req_valid); end
    @(negedge clk); #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL fetch_first_req got %b exp 1", imem_req_valid); end
    checks++; if (imem_req_addr !== RST_PC) begin errors++; $display("FAIL fetch_first_addr got %h exp %h", imem_req_addr, RST_PC); end
    @(negedge clk); #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fetch_early_valid got %b exp 0", inst_valid); end
    @(negedge clk); #1;
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL fetch_first_valid got %b exp 1", inst_valid); end
    checks++; if (inst_pc !== RST_PC) begin errors++; $display("FAIL fetch_first_pc got %h exp %h", inst_pc, RST_PC); end
    checks++; if (inst !== mem_word(RST_PC)) begin errors++; $display("FAIL fetch_first_inst got %h exp %h", inst, mem_word(RST_PC)); end
    repeat (20) @(negedge clk);
    checks++;
    if (req_log.size() < 8) begin
      errors++; $display("FAIL fetch_req_count got %0d exp >=8", req_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        logic [31:0] e;
        e = RST_PC + 32'(4 * i);
        checks++; if (req_log[i] !== e) begin errors++; $display("FAIL fetch_req_addr[%0d] got %h exp %h", i, req_log[i], e); end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    @(negedge clk);
    inst_ready = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid got %b exp 0", imem_req_valid); end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stall_inst_valid got %b exp 1", inst_valid); end
    checks++; if (acc_total - pop_total != 2) begin errors++; $display("FAIL stall_held got %0d exp 2", acc_total - pop_total); end
    e = RST_PC + 32'(4 * pop_total);
    checks++; if (inst_pc !== e) begin errors++; $display("FAIL stall_head_pc got %h exp %h", inst_pc, e); end
    @(negedge clk);
    inst_ready = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (obs_pc.size() < 12) begin
      errors++; $display("FAIL stall_pop_count got %0d exp >=12", obs_pc.size());
    end else begin
      for (int i = 0; i < obs_pc.size(); i++) begin
        e = RST_PC + 32'(4 * i);
        checks++; if (obs_pc[i] !== e) begin errors++; $display("FAIL stall_seq_pc[%0d] got %h exp %h", i, obs_pc[i], e); end
        checks++; if (obs_inst[i] !== mem_word(e)) begin errors++; $display("FAIL stall_seq_inst[%0d] got %h exp %h", i, obs_inst[i], mem_word(e)); end
      end
    end
  endtask

  task automatic test_redirect_inflight();
    bit found;
    test_reset();  // reset asserted while traffic is in flight
    mem_lat = 3; inst_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_log.size() >= 2) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL inflight_setup got %0d reqs exp 2", req_log.size()); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    clear_logs();
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL inflight_redir_req got %b exp 0", imem_req_valid); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL inflight_r1_req got %b exp 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h200) begin errors++; $display("FAIL inflight_r1_addr got %h exp 200", imem_req_addr); end
    repeat (15) @(negedge clk);
    checks++;
    if (obs_pc.size() < 2) begin
      errors++; $display("FAIL inflight_pops got %0d exp >=2", obs_pc.size());
    end else begin
      checks++; if (obs_pc[0] !== 32'h200) begin errors++; $display("FAIL inflight_pc0 got %h exp 200", obs_pc[0]); end
      checks++; if (obs_inst[0] !== mem_word(32'h200)) begin errors++; $display("FAIL inflight_inst0 got %h exp %h", obs_inst[0], mem_word(32'h200)); end
      checks++; if (obs_pc[1] !== 32'h204) begin errors++; $display("FAIL inflight_pc1 got %h exp 204", obs_pc[1]); end
    end
  endtask

  task automatic test_redirect_rsp_pop();
    bit found;
    do_reset();
    mem_lat = 2; inst_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (inst_valid && imem_rsp_valid) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rsppop_setup got 0 exp 1"); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    clear_logs();
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rsppop_flushed got %b exp 0", inst_valid); end
    checks++; if (imem_req_addr !== 32'h300) begin errors++; $display("FAIL rsppop_r1_addr got %h exp 300", imem_req_addr); end
    repeat (12) @(negedge clk);
    checks++;
    if (obs_pc.size() < 2 || req_log.size() < 1) begin
      errors++; $display("FAIL rsppop_counts got %0d pops %0d reqs exp >=2 >=1", obs_pc.size(), req_log.size());
    end else begin
      checks++; if (req_log[0] !== 32'h300) begin errors++; $display("FAIL rsppop_req0 got %h exp 300", req_log[0]); end
      checks++; if (obs_pc[0] !== 32'h300) begin errors++; $display("FAIL rsppop_pc0 got %h exp 300", obs_pc[0]); end
      checks++; if (obs_inst[0] !== mem_word(32'h300)) begin errors++; $display("FAIL rsppop_inst0 got %h exp %h", obs_inst[0], mem_word(32'h300)); end
      checks++; if (obs_pc[1] !== 32'h304) begin errors++; $display("FAIL rsppop_pc1 got %h exp 304", obs_pc[1]); end
    end
  endtask

  task automatic test_wrap();
    bit          prev_stall;
    logic [31:0] prev_addr, e;
    int          nstall;
    mem_lat = 1; rand_ready = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF0;
    clear_logs();
    @(negedge clk);
    redirect_valid = 1'b0;
    prev_stall = 1'b0; prev_addr = 32'h0; nstall = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk); #1;
      if (prev_stall) begin
        nstall++;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
          errors++; $display("FAIL wrap_hold got %b/%h exp 1/%h", imem_req_valid, imem_req_addr, prev_addr);
        end
      end
      prev_stall = imem_req_valid && !imem_req_ready;
      prev_addr  = imem_req_addr;
    end
    checks++; if (nstall == 0) begin errors++; $display("FAIL wrap_stalls got 0 exp >0"); end
    rand_ready = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (req_log.size() < 8 || obs_pc.size() < 8) begin
      errors++; $display("FAIL wrap_counts got %0d reqs %0d pops exp >=8", req_log.size(), obs_pc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        e = 32'hFFFF_FFF0 + 32'(4 * i);
        checks++; if (req_log[i] !== e) begin errors++; $display("FAIL wrap_req[%0d] got %h exp %h", i, req_log[i], e); end
        checks++; if (obs_pc[i] !== e) begin errors++; $display("FAIL wrap_pc[%0d] got %h exp %h", i, obs_pc[i], e); end
        checks++; if (obs_inst[i] !== mem_word(e)) begin errors++; $display("FAIL wrap_inst[%0d] got %h exp %h", i, obs_inst[i], mem_word(e)); end
      end
    end
  endtask

  task automatic test_misalign();
    inst_ready = 1'b1; rand_ready = 1'b0; mem_lat = 1;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0202;
    clear_logs();
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
`ifdef IF_MISALIGN_TRAP_EN
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_err_set got %b exp 1", misalign_err); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_req_blocked got %b exp 0", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h202) begin errors++; $display("FAIL mis_pc got %h exp 202", imem_req_addr); end
    repeat (6) @(negedge clk);
    #1;
    checks++; if (req_log.size() != 0) begin errors++; $display("FAIL mis_no_reqs got %0d exp 0", req_log.size()); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL mis_no_inst got %b exp 0", inst_valid); end
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_err_hold got %b exp 1", misalign_err); end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    clear_logs();
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_err_clear got %b exp 0", misalign_err); end
    repeat (12) @(negedge clk);
    checks++;
    if (req_log.size() < 1 || obs_pc.size() < 1) begin
      errors++; $display("FAIL mis_resume got %0d reqs %0d pops exp >=1", req_log.size(), obs_pc.size());
    end else begin
      checks++; if (req_log[0] !== 32'h300) begin errors++; $display("FAIL mis_req0 got %h exp 300", req_log[0]); end
      checks++; if (obs_pc[0] !== 32'h300) begin errors++; $display("FAIL mis_pc0 got %h exp 300", obs_pc[0]); end
    end
`else
    checks++; if (imem_req_addr !== 32'h200) begin errors++; $display("FAIL align_pc got %h exp 200", imem_req_addr); end
    repeat (12) @(negedge clk);
    checks++;
    if (req_log.size() < 1 || obs_pc.size() < 1) begin
      errors++; $display("FAIL align_resume got %0d reqs %0d pops exp >=1", req_log.size(), obs_pc.size());
    end else begin
      checks++; if (req_log[0] !== 32'h200) begin errors++; $display("FAIL align_req0 got %h exp 200", req_log[0]); end
      checks++; if (obs_pc[0] !== 32'h200) begin errors++; $display("FAIL align_pc0 got %h exp 200", obs_pc[0]); end
      checks++; if (obs_inst[0] !== mem_word(32'h200)) begin errors++; $display("FAIL align_inst0 got %h exp %h", obs_inst[0], mem_word(32'h200)); end
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin : main
    rst_n = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1 rst_n = 1'b0;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_inflight();
    test_redirect_rsp_pop();
    test_wrap();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
